// File: rtl/calc_sequencer.sv
// Three-operand sequencer for the 11-bit calculator datapath.
// Chains operands through an external ALU and keeps a sticky overflow.
module calc_sequencer #(
  parameter int MAX_OPERANDS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [10:0] op_data,
  input  logic [1:0]  op_code,
  input  logic        op_last,
  output logic [10:0] alu_a,
  output logic [10:0] alu_b,
  output logic [1:0]  alu_s,
  output logic        alu_en,
  input  logic [10:0] alu_q,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [10:0] res_q,
  output logic        res_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    EXEC,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] a_q, a_d;
  logic [10:0] b_q, b_d;
  logic [1:0]  s_q, s_d;
  logic        last_q, last_d;
  logic        hs;
  logic        unused_bit;

  // Bit 10 of an operand carries no information.
  assign unused_bit = op_data[10];

  assign op_ready  = ((state_q == IDLE) || (state_q == ACCEPT)) && !clr;
  assign hs        = op_valid && op_ready;
  assign alu_en    = (state_q == EXEC);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_q     = {ovf_q, acc_q};
  assign res_ovf   = ovf_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_s     = s_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    last_d  = last_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      s_d     = '0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hs) begin
            acc_d   = op_data[9:0];
            ovf_d   = 1'b0;
            cnt_d   = 3'd1;
            state_d = op_last ? DONE : ACCEPT;
          end
        end
        ACCEPT: begin
          if (hs) begin
            a_d     = {1'b0, acc_q};
            b_d     = {1'b0, op_data[9:0]};
            s_d     = op_code;
            cnt_d   = cnt_q + 3'd1;
            last_d  = op_last ||
                      ((cnt_q + 3'd1) == 3'(MAX_OPERANDS));
            state_d = EXEC;
          end
        end
        EXEC: begin
          acc_d   = alu_q[9:0];
          ovf_d   = ovf_q | alu_q[10];
          state_d = last_q ? DONE : ACCEPT;
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a behavioural ALU.
// Operand tasks wait on op_ready with a bounded cycle budget.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        op_valid;
  logic        op_ready;
  logic [10:0] op_data;
  logic [1:0]  op_code;
  logic        op_last;
  logic [10:0] alu_a;
  logic [10:0] alu_b;
  logic [1:0]  alu_s;
  logic        alu_en;
  logic [10:0] alu_q;
  logic        res_valid;
  logic        res_ready;
  logic [10:0] res_q;
  logic        res_ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int en_base;

  calc_sequencer #(.MAX_OPERANDS(3)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_data(op_data), .op_code(op_code),
    .op_last(op_last),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_en(alu_en), .alu_q(alu_q),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_en) en_cnt++;

  // 10-bit wrapping ALU with signed overflow in bit 10.
  logic [9:0] a10, b10, r10;
  logic       v;
  always_comb begin
    a10 = alu_a[9:0];
    b10 = alu_b[9:0];
    r10 = '0;
    v   = 1'b0;
    case (alu_s)
      2'd0: begin
        r10 = a10 + b10;
        v = (a10[9] == b10[9]) && (r10[9] != a10[9]);
      end
      2'd1: begin
        r10 = a10 - b10;
        v = (a10[9] != b10[9]) && (r10[9] != a10[9]);
      end
      2'd2: r10 = a10 & b10;
      default: r10 = a10 | b10;
    endcase
    alu_q = {v, r10};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [10:0] obs,
                     input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [10:0] d,
                       input logic [1:0] c,
                       input logic l);
    int n;
    n = 0;
    op_valid = 1'b1;
    op_data  = d;
    op_code  = c;
    op_last  = l;
    while (!op_ready && n < 10) begin
      tick();
      n++;
    end
    chk("hs_timeout", {10'd0, op_ready}, 11'd1);
    tick();
    op_valid = 1'b0;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drain_idle", {10'd0, busy}, 11'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    op_valid = 1'b0;
    op_data = '0;
    op_code = '0;
    op_last = 1'b0;
    res_ready = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ready", {10'd0, op_ready}, 11'd1);
    chk("rst_busy", {10'd0, busy}, 11'd0);
    chk("rst_en", {10'd0, alu_en}, 11'd0);
    chk("rst_rv", {10'd0, res_valid}, 11'd0);
    chk("rst_ovf", {10'd0, res_ovf}, 11'd0);
    chk("rst_a", alu_a, 11'd0);
    chk("rst_b", alu_b, 11'd0);
    chk("rst_s", {9'd0, alu_s}, 11'd0);
    chk("rst_res", res_q, 11'd0);

    // Chained add/sub: 5 + 3 - 2
    en_base = en_cnt;
    offer(11'd5, 2'd0, 1'b0);
    chk("ch_busy", {10'd0, busy}, 11'd1);
    offer(11'd3, 2'd0, 1'b0);
    chk("ch_en1", {10'd0, alu_en}, 11'd1);
    chk("ch_a1", alu_a, 11'd5);
    chk("ch_b1", alu_b, 11'd3);
    chk("ch_s1", {9'd0, alu_s}, 11'd0);
    chk("ch_rdy_exec", {10'd0, op_ready}, 11'd0);
    offer(11'd2, 2'd1, 1'b1);
    chk("ch_a2", alu_a, 11'd8);
    chk("ch_b2", alu_b, 11'd2);
    chk("ch_s2", {9'd0, alu_s}, 11'd1);
    chk("ch_rv_early", {10'd0, res_valid}, 11'd0);
    tick();
    chk("ch_rv", {10'd0, res_valid}, 11'd1);
    chk("ch_res", res_q, 11'h006);
    chk("ch_ovf", {10'd0, res_ovf}, 11'd0);
    chk("ch_en_cnt", 11'(en_cnt - en_base), 11'd2);
    drain();

    // Overflow, then flag cleared by next sequence
    offer(11'd500, 2'd0, 1'b0);
    offer(11'd20, 2'd0, 1'b1);
    tick();
    chk("ov_rv", {10'd0, res_valid}, 11'd1);
    chk("ov_res", res_q, 11'h608);
    chk("ov_flag", {10'd0, res_ovf}, 11'd1);
    drain();
    offer(11'd1, 2'd0, 1'b1);
    chk("ov2_rv", {10'd0, res_valid}, 11'd1);
    chk("ov2_res", res_q, 11'h001);
    chk("ov2_flag", {10'd0, res_ovf}, 11'd0);
    drain();

    // Forced termination, logic ops, backpressure
    offer(11'h0F0, 2'd0, 1'b0);
    offer(11'h0FF, 2'd2, 1'b0);
    offer(11'h300, 2'd3, 1'b0);
    tick();
    chk("ft_rv", {10'd0, res_valid}, 11'd1);
    chk("ft_res", res_q, 11'h3F0);
    op_valid = 1'b1;
    op_data  = 11'h011;
    op_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rdy", {10'd0, op_ready}, 11'd0);
      chk("bp_rv", {10'd0, res_valid}, 11'd1);
      chk("bp_res", res_q, 11'h3F0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    op_valid = 1'b0;
    chk("bp_idle", {10'd0, busy}, 11'd0);
    chk("bp_rv_off", {10'd0, res_valid}, 11'd0);
    tick();
    chk("bp_not_taken", {10'd0, busy}, 11'd0);

    // Single operand with bit 10 set
    offer(11'h7F9, 2'd0, 1'b1);
    chk("so_rv", {10'd0, res_valid}, 11'd1);
    chk("so_res", res_q, 11'h3F9);
    chk("so_ovf", {10'd0, res_ovf}, 11'd0);
    drain();

    // clr during EXEC
    offer(11'd5, 2'd0, 1'b0);
    offer(11'd7, 2'd0, 1'b0);
    chk("cl_exec", {10'd0, alu_en}, 11'd1);
    clr = 1'b1;
    #1;
    chk("cl_rdy", {10'd0, op_ready}, 11'd0);
    tick();
    clr = 1'b0;
    chk("cl_busy", {10'd0, busy}, 11'd0);
    chk("cl_res", res_q, 11'd0);
    chk("cl_a", alu_a, 11'd0);
    chk("cl_b", alu_b, 11'd0);
    chk("cl_s", {9'd0, alu_s}, 11'd0);
    chk("cl_rv", {10'd0, res_valid}, 11'd0);

    // Reset while in ACCEPT
    offer(11'd9, 2'd0, 1'b0);
    chk("ra_acc", res_q, 11'h009);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ra_busy", {10'd0, busy}, 11'd0);
    chk("ra_res", res_q, 11'd0);
    chk("ra_a", alu_a, 11'd0);
    chk("ra_rv", {10'd0, res_valid}, 11'd0);

    // clr with op_valid in IDLE
    clr = 1'b1;
    op_valid = 1'b1;
    op_data = 11'h055;
    op_last = 1'b1;
    #1;
    chk("ci_rdy", {10'd0, op_ready}, 11'd0);
    tick();
    clr = 1'b0;
    op_valid = 1'b0;
    chk("ci_busy", {10'd0, busy}, 11'd0);
    chk("ci_rv", {10'd0, res_valid}, 11'd0);
    chk("ci_res", res_q, 11'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
